// File: rtl/axi_burst_write_ctrl.sv
// Write-side AXI master: splits one (address, beat count) command into INCR bursts
// of at most MAX_BURST beats and sequences AW -> W -> B for each, one burst in flight.
module axi_burst_write_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_beats,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  output logic                  wlast,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] rem;
  logic [LEN_WIDTH-1:0] rem_left;
  logic [8:0]           blen;
  logic [8:0]           beat_cnt;
  logic                 cmd_fire, aw_fire, w_fire, b_fire;
  logic                 unused_bresp0;

  function automatic logic [8:0] burst_len(input logic [LEN_WIDTH-1:0] r);
    if (r >= LEN_WIDTH'(MAX_BURST)) burst_len = 9'(MAX_BURST);
    else                            burst_len = 9'(r);
  endfunction

  assign cmd_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign cmd_fire      = cmd_valid && cmd_ready;
  assign aw_fire       = awvalid && awready;
  assign b_fire        = bvalid && bready;
  assign unused_bresp0 = bresp[0];

  // W channel is a straight pass-through of the producer while in W
  assign wvalid    = (state == S_W) && src_valid;
  assign wdata     = src_data;
  assign src_ready = (state == S_W) && wready;
  assign wlast     = (state == S_W) && (beat_cnt == blen - 9'd1);
  assign w_fire    = wvalid && wready;

  assign rem_left  = rem - LEN_WIDTH'(blen);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (cmd_fire) state_nxt = (cmd_beats == '0) ? S_DONE : S_AW;
      S_AW:   if (aw_fire) state_nxt = S_W;
      S_W:    if (w_fire && wlast) state_nxt = S_B;
      S_B:    if (b_fire) state_nxt = (rem_left == '0) ? S_DONE : S_AW;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // awaddr doubles as the running word address; it only advances on B handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awaddr   <= '0;
      awlen    <= '0;
      awvalid  <= 1'b0;
      bready   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rem      <= '0;
      blen     <= '0;
      beat_cnt <= '0;
    end else begin
      done <= (state_nxt == S_DONE);
      unique case (state)
        S_IDLE: if (cmd_fire) begin
          awaddr  <= cmd_addr;
          rem     <= cmd_beats;
          blen    <= burst_len(cmd_beats);
          awlen   <= 8'(burst_len(cmd_beats) - 9'd1);
          err     <= 1'b0;
          awvalid <= (cmd_beats != '0);
        end
        S_AW: if (aw_fire) begin
          awvalid  <= 1'b0;
          beat_cnt <= '0;
        end
        S_W: if (w_fire) begin
          beat_cnt <= beat_cnt + 9'd1;
          if (wlast) bready <= 1'b1;
        end
        S_B: if (b_fire) begin
          bready  <= 1'b0;
          err     <= err | bresp[1];
          awaddr  <= awaddr + ADDR_WIDTH'(blen);
          rem     <= rem_left;
          blen    <= burst_len(rem_left);
          awlen   <= 8'(burst_len(rem_left) - 9'd1);
          awvalid <= (rem_left != '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_write_ctrl.sv
// Directed bench for axi_burst_write_ctrl: a table of commands run against a
// bench-side AXI slave/producer, plus hand sequences for zero-length and mid-burst reset.
module tb_axi_burst_write_ctrl;
  localparam int MB = 16;
  localparam logic [31:0] DATA_BASE = 32'hA500_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_beats = '0;
  logic [31:0] src_data = '0;
  logic        src_valid = 1'b0, src_ready;
  logic        busy, done, err;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid, awready = 1'b0;
  logic [31:0] wdata;
  logic        wvalid, wready = 1'b0, wlast;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0, bready;

  always #5 clk = ~clk;

  axi_burst_write_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .busy(busy), .done(done), .err(err),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [15:0] beats;
    bit          src_toggle;
    bit          w_stall;
    int          err_burst;   // burst index answered with 2'b10, -1 for none
    bit          exp_err;
    int          exp_bursts;
  } vec_t;

  vec_t vecs[9];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] a, input int i);
    return a + 32'(i * MB);
  endfunction

  function automatic logic [7:0] exp_len(input logic [15:0] beats, input int i);
    int r;
    r = int'(beats) - i * MB;
    if (r > MB) r = MB;
    return 8'(r - 1);
  endfunction

  task automatic idle_inputs();
    cmd_valid = 1'b0; src_valid = 1'b0; awready = 1'b0;
    wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic run_vec(input vec_t v);
    bit accepted = 0, finished = 0, pulse, aw_wait = 0, aw_first = 0, b_pending = 0;
    int accept_cyc = 0, done_cyc = 0, aw_n = 0, b_n = 0, beat_n = 0, bib = 0;
    int wlast_n = 0, done_n = 0, stall_n = 0;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(posedge clk); #1;
      pulse     = accepted && (cyc == accept_cyc + 2);
      cmd_valid = !accepted || pulse;
      cmd_addr  = pulse ? 32'hDEAD_0000 : v.addr;
      cmd_beats = pulse ? 16'd5 : v.beats;
      src_valid = v.src_toggle ? ((cyc % 2) == 0) : 1'b1;
      src_data  = DATA_BASE + 32'(beat_n);
      wready    = !(v.w_stall && beat_n == 3 && stall_n < 3);
      awready   = aw_wait;
      bvalid    = b_pending;
      bresp     = (b_n == v.err_burst) ? 2'b10 : 2'b01;
      #1;
      if (!accepted) begin
        if (cmd_ready) begin accepted = 1; accept_cyc = cyc; end
      end else if (pulse) check("busy_cmd_ready", cmd_ready, 0);
      if (awvalid) begin
        if (!aw_first) begin
          aw_first = 1;
          check("aw_latency", cyc - accept_cyc, 1);
        end
        if (awready) begin
          check("awaddr", awaddr, exp_addr(v.addr, aw_n));
          check("awlen", awlen, exp_len(v.beats, aw_n));
          check("one_outstanding", aw_n, b_n);
          aw_n++; aw_wait = 0; bib = 0;
        end else aw_wait = 1;
      end
      if (!wready) stall_n++;
      if (wvalid && !wready) check("wdata_hold", wdata, DATA_BASE + 32'(beat_n));
      if (wvalid && wready) begin
        check("wdata", wdata, DATA_BASE + 32'(beat_n));
        check("wlast", wlast, bib == int'(exp_len(v.beats, aw_n - 1)));
        if (wlast) begin wlast_n++; b_pending = 1; end
        beat_n++; bib++;
      end
      if (bvalid && bready) begin b_n++; b_pending = 0; end
      if (done) begin
        done_n++;
        check("done_err", err, v.exp_err);
        if (done_n == 1) done_cyc = cyc;
      end
      if (done_n > 0 && cyc >= done_cyc + 4) finished = 1;
    end
    idle_inputs();
    check("done_count", done_n, 1);
    check("aw_count", aw_n, v.exp_bursts);
    check("b_count", b_n, v.exp_bursts);
    check("beat_count", beat_n, v.beats);
    check("wlast_count", wlast_n, v.exp_bursts);
  endtask

  task automatic zero_beats();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 32'h700; cmd_beats = 16'd0;
    #1 check("zero_accept", cmd_ready, 1);
    @(posedge clk); #1;                 // cmd_valid held high while busy
    #1;
    check("zero_done", done, 1);
    check("zero_err_cleared", err, 0);
    check("zero_busy", busy, 1);
    check("zero_no_aw", awvalid, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #1;
    check("zero_done_drop", done, 0);
    check("zero_idle", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("zero_no_second_done", done, 0);
      check("zero_no_aw_late", awvalid, 0);
    end
  endtask

  task automatic reset_mid_burst();
    int beats_seen = 0;
    bit acc = 0;
    for (int cyc = 0; cyc < 20 && beats_seen < 1; cyc++) begin
      @(posedge clk); #1;
      cmd_valid = !acc; cmd_addr = 32'h300; cmd_beats = 16'd4;
      awready = 1'b1; wready = 1'b1; src_valid = 1'b1;
      src_data = DATA_BASE + 32'(beats_seen);
      #1;
      if (!acc && cmd_ready) acc = 1;
      if (wvalid && wready) beats_seen++;
    end
    check("rst_reached_w", beats_seen, 1);
    @(posedge clk); #1;
    src_data = DATA_BASE + 32'd1;
    rst_n = 1'b0;                       // reset lands on the edge of beat 2
    @(posedge clk); #1;
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_wlast", wlast, 0);
    check("rst_bready", bready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    idle_inputs();
    @(posedge clk); #2;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_no_done", done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           addr          beats   tog str errb err bursts
    vecs[0] = '{32'h0000_0010, 16'd4,  0,  0,  -1,  0,  1};
    vecs[1] = '{32'h0000_0000, 16'd40, 0,  0,  -1,  0,  3};
    vecs[2] = '{32'h0000_0100, 16'd8,  1,  1,  -1,  0,  1};
    vecs[3] = '{32'h0000_0200, 16'd48, 0,  0,   1,  1,  3};
    vecs[4] = '{32'h0000_0200, 16'd48, 0,  0,  -1,  0,  3};
    vecs[5] = '{32'hFFFF_FFF8, 16'd20, 0,  0,  -1,  0,  2};
    vecs[6] = '{32'h0000_0040, 16'd16, 0,  0,  -1,  0,  1};
    vecs[7] = '{32'h0000_0050, 16'd17, 0,  0,   0,  1,  2};
    vecs[8] = '{32'h0000_0060, 16'd1,  1,  0,  -1,  0,  1};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_awvalid", awvalid, 0);
    check("reset_awaddr", awaddr, 0);
    check("reset_awlen", awlen, 0);
    check("reset_bready", bready, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_busy", busy, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    run_vec(vecs[3]);                   // leaves err=1 so the zero-beat accept must clear it
    zero_beats();
    reset_mid_burst();
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
